// File: rtl/coherence_ctrl_if.sv
// Bus bundle between coherence_ctrl, the two data caches and the shared RAM port.
// slave: controller side; master: caches and RAM side.
interface coherence_ctrl_if #(
    parameter int WORD_W = 32
);
    logic [1:0]             dREN;
    logic [1:0]             dWEN;
    logic [1:0][WORD_W-1:0] daddr;
    logic [1:0][WORD_W-1:0] dstore;
    logic [1:0]             cctrans;
    logic [1:0]             ccwrite;
    logic [1:0]             dwait;
    logic [1:0][WORD_W-1:0] dload;
    logic [1:0]             ccwait;
    logic [1:0]             ccinv;
    logic [1:0][WORD_W-1:0] ccsnoopaddr;
    logic                   ramREN;
    logic                   ramWEN;
    logic [WORD_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;
    logic [WORD_W-1:0]      ramload;
    logic                   ramwait;

    modport slave (
        input  dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramwait,
        output dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramwait,
        input  dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_ctrl.sv
// Two-cache snoopy bus controller and RAM arbiter.
// Snooping is built only when COHERENCE_SNOOP_EN is defined; otherwise grants go straight to RAM.
module coherence_ctrl #(
    parameter int WORD_W = 32
) (
    input logic             CLK,
    input logic             RST,
    coherence_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SNOOP,
        SNOOP_RESP,
        PEER_WB,
        ACCESS
    } state_t;

    state_t                 state;
    logic                   owner;
    logic                   last;
    logic                   win;
    logic [1:0]             req;
    logic [1:0]             ccwait_q;
    logic [1:0]             ccinv_q;
    logic [1:0][WORD_W-1:0] snoop_addr_q;
`ifdef COHERENCE_SNOOP_EN
    logic                   peer;
    logic                   wb_cnt;

    assign peer = ~owner;
`endif

    assign req = bus.dREN | bus.dWEN | bus.cctrans;

    always_comb begin
        win = req[1];
        if (&req) win = ~last;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last         <= 1'b1;
            ccwait_q     <= '0;
            ccinv_q      <= '0;
            snoop_addr_q <= '0;
`ifdef COHERENCE_SNOOP_EN
            wb_cnt       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // last follows every grant so a lone requester also yields the next tie
                    if (|req) begin
                        owner <= win;
                        last  <= win;
                        state <= GRANT;
                    end
                end
                GRANT: begin
`ifdef COHERENCE_SNOOP_EN
                    if (bus.cctrans[owner]) begin
                        ccwait_q[peer]     <= 1'b1;
                        ccinv_q[peer]      <= bus.ccwrite[owner];
                        snoop_addr_q[peer] <= bus.daddr[owner];
                        state              <= SNOOP;
                    end else begin
                        state <= ACCESS;
                    end
`else
                    state <= ACCESS;
`endif
                end
`ifdef COHERENCE_SNOOP_EN
                SNOOP: state <= SNOOP_RESP;
                SNOOP_RESP: begin
                    if (bus.cctrans[peer] && bus.ccwrite[peer]) begin
                        wb_cnt <= 1'b0;
                        state  <= PEER_WB;
                    end else begin
                        ccwait_q <= '0;
                        ccinv_q  <= '0;
                        state    <= ACCESS;
                    end
                end
                PEER_WB: begin
                    if (bus.dWEN[peer] && !bus.ramwait) begin
                        wb_cnt <= 1'b1;
                        if (wb_cnt) begin
                            ccwait_q <= '0;
                            ccinv_q  <= '0;
                            state    <= ACCESS;
                        end
                    end
                end
`endif
                ACCESS: begin
                    if (!req[owner]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ccwait      = ccwait_q;
    assign bus.ccinv       = ccinv_q;
    assign bus.ccsnoopaddr = snoop_addr_q;

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.dwait    = 2'b11;
        bus.dload    = '0;
        case (state)
            ACCESS: begin
                bus.ramWEN        = bus.dWEN[owner];
                bus.ramREN        = bus.dREN[owner] & ~bus.dWEN[owner];
                bus.ramaddr       = bus.daddr[owner];
                bus.ramstore      = bus.dstore[owner];
                bus.dload[owner]  = bus.ramload;
                bus.dwait[owner]  = ~((bus.dREN[owner] | bus.dWEN[owner]) & ~bus.ramwait);
            end
`ifdef COHERENCE_SNOOP_EN
            PEER_WB: begin
                bus.ramWEN       = bus.dWEN[peer];
                bus.ramaddr      = bus.daddr[peer];
                bus.ramstore     = bus.dstore[peer];
                bus.dwait[peer]  = ~(bus.dWEN[peer] & ~bus.ramwait);
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_coherence_ctrl.sv
// Directed self-checking bench for coherence_ctrl; snoop steps follow COHERENCE_SNOOP_EN.
module tb_coherence_ctrl;
    localparam int W = 32;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    coherence_ctrl_if #(.WORD_W(W)) bus ();

    coherence_ctrl #(.WORD_W(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.dREN    = '0;
        bus.dWEN    = '0;
        bus.daddr   = '0;
        bus.dstore  = '0;
        bus.cctrans = '0;
        bus.ccwrite = '0;
        bus.ramload = '0;
        bus.ramwait = 1'b1;
        RST         = 1'b1;

        // Reset with both caches requesting
        bus.dREN     = 2'b11;
        bus.daddr[0] = 32'h10;
        bus.daddr[1] = 32'h20;
        cyc(); cyc(); #1;
        chk("rst_dwait", bus.dwait, 2'b11);
        chk("rst_ccwait", bus.ccwait, 2'b00);
        chk("rst_ccinv", bus.ccinv, 2'b00);
        chk("rst_ramREN", bus.ramREN, 1'b0);
        chk("rst_ramWEN", bus.ramWEN, 1'b0);
        chk("rst_ramaddr", bus.ramaddr, 32'h0);
        chk("rst_dload0", bus.dload[0], 32'h0);
        chk("rst_snoopaddr1", bus.ccsnoopaddr[1], 32'h0);
        RST = 1'b0;
        cyc(); #1;
        chk("first_grant_dwait", bus.dwait, 2'b11);
        chk("first_grant_ramREN", bus.ramREN, 1'b0);
        cyc();
        bus.ramwait = 1'b0;
        bus.ramload = 32'hAA;
        #1;
        chk("first_owner_addr", bus.ramaddr, 32'h10);
        chk("first_owner_dwait", bus.dwait, 2'b10);
        chk("first_owner_ramREN", bus.ramREN, 1'b1);
        chk("first_owner_dload", bus.dload[0], 32'hAA);
        bus.dREN    = 2'b00;
        bus.ramwait = 1'b1;
        cyc();

        // Clean read miss from cache 0
        bus.cctrans  = 2'b01;
        bus.dREN     = 2'b01;
        bus.daddr[0] = 32'h100;
        #1;
        chk("idle_dwait", bus.dwait, 2'b11);
        cyc(); #1;
        chk("miss_grant_ccwait", bus.ccwait, 2'b00);
        chk("miss_grant_dwait", bus.dwait, 2'b11);
`ifdef COHERENCE_SNOOP_EN
        cyc(); #1;
        chk("snoop_ccwait", bus.ccwait, 2'b10);
        chk("snoop_addr1", bus.ccsnoopaddr[1], 32'h100);
        chk("snoop_ccinv", bus.ccinv, 2'b00);
        chk("snoop_ramREN", bus.ramREN, 1'b0);
        cyc(); #1;
        chk("resp_ccwait", bus.ccwait, 2'b10);
        chk("resp_ramREN", bus.ramREN, 1'b0);
`endif
        cyc(); #1;
        chk("miss_acc_ccwait", bus.ccwait, 2'b00);
        chk("miss_acc_ramREN", bus.ramREN, 1'b1);
        chk("miss_acc_ramaddr", bus.ramaddr, 32'h100);
        chk("miss_acc_wait1", bus.dwait, 2'b11);
        cyc(); #1;
        chk("miss_acc_wait2", bus.dwait, 2'b11);
        cyc();
        bus.ramwait = 1'b0;
        bus.ramload = 32'hDEAD;
        #1;
        chk("miss_done_dwait", bus.dwait, 2'b10);
        chk("miss_done_dload", bus.dload[0], 32'hDEAD);
        bus.dREN    = 2'b00;
        bus.cctrans = 2'b00;
        bus.ramwait = 1'b1;
        cyc();

        // Cache 1 write miss; cache 0 holds the line dirty
        bus.cctrans  = 2'b10;
        bus.ccwrite  = 2'b10;
        bus.dREN     = 2'b10;
        bus.daddr[1] = 32'h200;
        cyc(); #1;
        chk("dirty_grant_dwait", bus.dwait, 2'b11);
`ifdef COHERENCE_SNOOP_EN
        cyc(); #1;
        chk("dirty_snoop_ccwait", bus.ccwait, 2'b01);
        chk("dirty_snoop_ccinv", bus.ccinv, 2'b01);
        chk("dirty_snoop_addr0", bus.ccsnoopaddr[0], 32'h200);
        bus.cctrans = 2'b11;
        bus.ccwrite = 2'b11;
        cyc();
        bus.dWEN      = 2'b01;
        bus.daddr[0]  = 32'h200;
        bus.dstore[0] = 32'h11;
        #1;
        chk("dirty_resp_ramWEN", bus.ramWEN, 1'b0);
        chk("dirty_resp_ramREN", bus.ramREN, 1'b0);
        chk("dirty_resp_ccwait", bus.ccwait, 2'b01);
        cyc(); #1;
        chk("wb1_ramWEN", bus.ramWEN, 1'b1);
        chk("wb1_ramREN", bus.ramREN, 1'b0);
        chk("wb1_ramaddr", bus.ramaddr, 32'h200);
        chk("wb1_ramstore", bus.ramstore, 32'h11);
        chk("wb1_dwait_busy", bus.dwait, 2'b11);
        chk("wb1_ccinv", bus.ccinv, 2'b01);
        cyc();
        bus.ramwait = 1'b0;
        #1;
        chk("wb1_dwait_done", bus.dwait, 2'b10);
        chk("wb1_done_ramREN", bus.ramREN, 1'b0);
        cyc();
        bus.daddr[0]  = 32'h204;
        bus.dstore[0] = 32'h22;
        #1;
        chk("wb2_ramaddr", bus.ramaddr, 32'h204);
        chk("wb2_ramstore", bus.ramstore, 32'h22);
        chk("wb2_dwait", bus.dwait, 2'b10);
        chk("wb2_ccwait", bus.ccwait, 2'b01);
        chk("wb2_ccinv", bus.ccinv, 2'b01);
        chk("wb2_ramREN", bus.ramREN, 1'b0);
        cyc();
        bus.dWEN    = 2'b00;
        bus.cctrans = 2'b10;
        bus.ccwrite = 2'b10;
        bus.ramwait = 1'b1;
        #1;
        chk("after_wb_ccwait", bus.ccwait, 2'b00);
        chk("after_wb_ccinv", bus.ccinv, 2'b00);
        chk("after_wb_ramWEN", bus.ramWEN, 1'b0);
`else
        cyc(); #1;
        chk("nosnoop_ccwait", bus.ccwait, 2'b00);
        chk("nosnoop_ccinv", bus.ccinv, 2'b00);
`endif
        chk("fill_ramREN", bus.ramREN, 1'b1);
        chk("fill_ramaddr", bus.ramaddr, 32'h200);
        chk("fill_dwait_busy", bus.dwait, 2'b11);
        bus.ramwait = 1'b0;
        bus.ramload = 32'h11;
        #1;
        chk("fill_dwait_done", bus.dwait, 2'b01);
        chk("fill_dload1", bus.dload[1], 32'h11);
        bus.dREN    = 2'b00;
        bus.cctrans = 2'b00;
        bus.ccwrite = 2'b00;
        bus.ramwait = 1'b1;
        cyc();

        // Tie twice: grants 0, 1, 0
        bus.dWEN      = 2'b11;
        bus.daddr[0]  = 32'h40;
        bus.daddr[1]  = 32'h80;
        bus.dstore[0] = 32'hA0;
        bus.dstore[1] = 32'hB0;
        bus.ramwait   = 1'b0;
        cyc(); #1;
        chk("tie1_grant_ramWEN", bus.ramWEN, 1'b0);
        chk("tie1_grant_dwait", bus.dwait, 2'b11);
        cyc(); #1;
        chk("tie1_ramaddr", bus.ramaddr, 32'h40);
        chk("tie1_dwait", bus.dwait, 2'b10);
        bus.dWEN = 2'b10;
        cyc(); #1;
        chk("tie_idle_dwait", bus.dwait, 2'b11);
        chk("tie_idle_ramWEN", bus.ramWEN, 1'b0);
        cyc(); cyc(); #1;
        chk("tie2_ramaddr", bus.ramaddr, 32'h80);
        chk("tie2_ramstore", bus.ramstore, 32'hB0);
        chk("tie2_dwait", bus.dwait, 2'b01);
        bus.dWEN = 2'b00;
        cyc();
        bus.dWEN = 2'b11;
        cyc(); cyc(); #1;
        chk("tie3_ramaddr", bus.ramaddr, 32'h40);
        chk("tie3_dwait", bus.dwait, 2'b10);
        bus.dWEN    = 2'b00;
        bus.ramwait = 1'b1;
        cyc();

        // Eviction write from cache 1
        bus.dWEN      = 2'b10;
        bus.daddr[1]  = 32'h3F8;
        bus.dstore[1] = 32'hBEEF;
        cyc(); #1;
        chk("evict_grant_ccwait", bus.ccwait, 2'b00);
        cyc(); #1;
        chk("evict_ccwait", bus.ccwait, 2'b00);
        chk("evict_ramWEN", bus.ramWEN, 1'b1);
        chk("evict_ramREN", bus.ramREN, 1'b0);
        chk("evict_ramaddr", bus.ramaddr, 32'h3F8);
        chk("evict_ramstore", bus.ramstore, 32'hBEEF);
        chk("evict_dwait_busy", bus.dwait, 2'b11);
        bus.ramwait = 1'b0;
        #1;
        chk("evict_dwait_done", bus.dwait, 2'b01);
        bus.dWEN    = 2'b00;
        bus.ramwait = 1'b1;
        cyc();

        // Reset while a write is on the RAM port
`ifdef COHERENCE_SNOOP_EN
        bus.cctrans  = 2'b01;
        bus.ccwrite  = 2'b01;
        bus.dREN     = 2'b01;
        bus.daddr[0] = 32'h300;
        cyc();
        cyc();
        bus.cctrans   = 2'b11;
        bus.ccwrite   = 2'b11;
        bus.dWEN      = 2'b10;
        bus.daddr[1]  = 32'h300;
        bus.dstore[1] = 32'h55;
        cyc();
        cyc(); #1;
        chk("midrst_pre_ccwait", bus.ccwait, 2'b10);
`else
        bus.dWEN      = 2'b10;
        bus.daddr[1]  = 32'h300;
        bus.dstore[1] = 32'h55;
        cyc();
        cyc(); #1;
`endif
        chk("midrst_pre_ramWEN", bus.ramWEN, 1'b1);
        chk("midrst_pre_ramaddr", bus.ramaddr, 32'h300);
        RST = 1'b1;
        cyc(); #1;
        chk("midrst_ramWEN", bus.ramWEN, 1'b0);
        chk("midrst_ramREN", bus.ramREN, 1'b0);
        chk("midrst_ccwait", bus.ccwait, 2'b00);
        chk("midrst_ccinv", bus.ccinv, 2'b00);
        chk("midrst_dwait", bus.dwait, 2'b11);
        chk("midrst_ramaddr", bus.ramaddr, 32'h0);
        chk("midrst_snoopaddr1", bus.ccsnoopaddr[1], 32'h0);
        RST          = 1'b0;
        bus.cctrans  = 2'b00;
        bus.ccwrite  = 2'b00;
        bus.dREN     = 2'b00;
        bus.dWEN     = 2'b10;
        bus.daddr[1] = 32'h3F0;
        cyc(); #1;
        chk("postrst_grant_ramWEN", bus.ramWEN, 1'b0);
        cyc(); #1;
        chk("postrst_ramWEN", bus.ramWEN, 1'b1);
        chk("postrst_ramaddr", bus.ramaddr, 32'h3F0);
        bus.dWEN = 2'b00;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/coherence_ctrl.md
# coherence_ctrl

Two-cache snoopy bus controller and memory arbiter that sits between the two per-core data caches and the shared RAM port. It is the responder side of the cache coherence interface. It grants one cache at a time and forwards word reads and writes to RAM. For each coherent miss it snoops the other cache: it raises `ccwait`, drives `ccsnoopaddr` and `ccinv`, and absorbs any dirty write-back from the snooped cache before the requester's line fill proceeds.

## Interface
Parameters:
- `WORD_W`, default 32, data and address width.

Ports:
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  synchronous reset, active-high.
- `dREN`  in  2  per-cache word read request.
- `dWEN`  in  2  per-cache word write request.
- `daddr`  in  2×WORD_W  per-cache word address.
- `dstore`  in  2×WORD_W  per-cache write data.
- `cctrans`  in  2  per-cache coherent transaction / snoop-response flag.
- `ccwrite`  in  2  per-cache write intent (miss) or dirty-hit (snoop response).
- `dwait`  out  2  per-cache stall; low for one cycle when a word completes.
- `dload`  out  2×WORD_W  per-cache read data, valid when `dwait[i]`=0.
- `ccwait`  out  2  snoop-in-progress to cache i.
- `ccinv`  out  2  invalidate hint to snooped cache.
- `ccsnoopaddr`  out  2×WORD_W  snoop address to cache i.
- `ramREN`, `ramWEN`  out  1  RAM read / write strobes.
- `ramaddr`, `ramstore`  out  WORD_W  RAM address and write data.
- `ramload`  in  WORD_W  RAM read data.
- `ramwait`  in  1  RAM busy; the word completes in a cycle with the strobe high and `ramwait`=0.

## Operation
- States: IDLE, GRANT, SNOOP, SNOOP_RESP, PEER_WB, ACCESS.
- **Reset values.** `dwait`=2'b11, `dload`=0, `ccwait`=0, `ccinv`=0, `ccsnoopaddr`=0, all `ram*`=0. State is IDLE; the round-robin pointer `last`=1, so cache 0 wins the first tie.
- **IDLE.** A request is `dREN|dWEN|cctrans` on a cache. Pick the owner:
  - one requester: that cache;
  - two requesters: the cache ≠ `last`; update `last` to the winner.
  - Then go to GRANT.
- **GRANT.**
  - Owner `cctrans`=1 (coherent miss): go to SNOOP.
  - Otherwise (eviction, flush, plain write-back): go to ACCESS.
- **SNOOP** (one cycle).
  - Peer p: `ccwait[p]`=1, `ccsnoopaddr[p]`=`daddr[owner]`, `ccinv[p]`=`ccwrite[owner]`.
  - Go to SNOOP_RESP.
- **SNOOP_RESP.** Keep the snoop outputs held.
  - `cctrans[p]&ccwrite[p]`: peer holds a dirty copy; go to PEER_WB.
  - Otherwise: drop `ccwait[p]` and go to ACCESS.
- **PEER_WB.**
  - Forward the peer's `dWEN`/`daddr`/`dstore` to RAM and drive `dwait[p]` from RAM completion.
  - Count 2 completed words; after the second, drop `ccwait[p]`/`ccinv[p]` and go to ACCESS.
  - The owner sees `dwait`=1 throughout.
- **ACCESS.**
  - Forward the owner's `dREN`/`dWEN` to RAM; `dload[owner]`=`ramload`; `dwait[owner]`=`ramwait` while a strobe is active.
  - Stay while the owner keeps `dREN|dWEN|cctrans` high.
  - When all three are low, go to IDLE.
- **Non-owner.** `dwait` held at 1 and its requests ignored (held for the next arbitration).
- **Simultaneous events.**
  - A peer request during a snoop is not granted.
  - Peer `dREN` during PEER_WB is ignored.
  - `dREN&dWEN` together: the write wins.
- **RAM strobes.** Never both high.
- **Reset mid-transaction.** All outputs return to reset values the cycle after `RST` is sampled. No RAM strobe stays active.

## Timing
- Grant latency: IDLE→GRANT is one cycle after the request is sampled.
- Clean snoop overhead: 3 cycles (GRANT, SNOOP, SNOOP_RESP) before the first ACCESS strobe.
- A word completes in the same cycle `ramwait` falls. `dwait` and `dload` are combinational from RAM in ACCESS/PEER_WB.
- `ccwait[p]` is high from SNOOP through the last PEER_WB word, and drops the cycle after.
- The peer's response in SNOOP_RESP is sampled exactly one cycle after `ccwait[p]` rises.

## Configuration
- `COHERENCE_SNOOP_EN` defined:
  - full behaviour above.
- Undefined:
  - GRANT always goes to ACCESS; SNOOP, SNOOP_RESP and PEER_WB are unreachable.
  - `ccwait`, `ccinv` and `ccsnoopaddr` are tied to 0.
  - `cctrans` is still a request source.

## Test plan
- **Reset.** Hold `RST` 2 cycles with `dREN`=2'b11 → `dwait`=11, `ccwait`=00, `ramREN`=0; first grant goes to cache 0.
- **Clean read miss.**
  - Stimulus: cache 0 `cctrans`=1, `dREN`=1, `daddr`=0x100; RAM 2-cycle latency returning 0xDEAD.
  - Response: `ccwait[1]`=1 and `ccsnoopaddr[1]`=0x100 in SNOOP; `ccinv[1]`=0; `dload[0]`=0xDEAD with `dwait[0]`=0.
- **Dirty snoop.**
  - Stimulus: cache 1 `ccwrite`=1 miss at 0x200; cache 0 answers `cctrans`=`ccwrite`=1 and writes 0x11/0x22 to 0x200/0x204.
  - Response: RAM writes occur before any `ramREN` for cache 1; `ccinv[0]`=1 throughout; `ccwait[0]` drops after word 2.
- **Tie.** `dWEN`=11 in the same cycle, twice in succession → grants go 0, then 1, then 0.
- **Eviction write.** Cache 1 `dWEN`=1, `cctrans`=0, `daddr`=0x3F8 → no `ccwait` asserted; `ramWEN`=1 with `ramaddr`=0x3F8.
- **Reset mid-PEER_WB.** Assert `RST` with `ramWEN`=1 → the next cycle `ramWEN`=0, `ccwait`=00, state IDLE.
